// File: rtl/fifo_flow_ctrl.sv
// Synchronous FIFO with a registered read port, an occupancy counter, hysteresis
// pause backpressure and a sticky overflow/underflow error flag.
module fifo_flow_ctrl #(
  parameter  int BITNUMBER = 8,
  parameter  int LENGTH    = 8,
  localparam int CNTW      = $clog2(LENGTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Fifo_wr,
  input  logic [BITNUMBER-1:0] Fifo_Data_in,
  input  logic                 Fifo_rd,
  input  logic [CNTW-1:0]      umbral_alto,
  input  logic [CNTW-1:0]      umbral_bajo,
  output logic [BITNUMBER-1:0] Fifo_Data_out,
  output logic                 Fifo_valid_out,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [CNTW-1:0]      fifo_count,
  output logic                 pause,
  output logic                 error,
  output logic                 dbg_state
);

  localparam int PTRW = $clog2(LENGTH);

  typedef enum logic {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_e;

  logic [BITNUMBER-1:0] r_mem [LENGTH];
  logic [PTRW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CNTW-1:0]      r_count;
  logic [CNTW-1:0]      w_next_count;
  logic                 r_error;
  state_e               r_state, w_state_nxt;
  logic                 w_wr_ok, w_rd_ok, w_overflow, w_underflow;

  // Request/accept: a read is accepted when Fifo_rd is high and the FIFO is not
  // empty; a write when Fifo_wr is high and there is room, or a read frees one
  // slot on the same edge. Rejected requests only set the sticky error.
  assign w_rd_ok     = Fifo_rd && !empty;
  assign w_wr_ok     = Fifo_wr && (!full || w_rd_ok);
  assign w_overflow  = Fifo_wr && full && !w_rd_ok;
  assign w_underflow = Fifo_rd && empty;

  assign full         = (r_count == CNTW'(LENGTH));
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= CNTW'(LENGTH - 1));
  assign almost_empty = (r_count <= CNTW'(1));
  assign fifo_count   = r_count;
  assign error        = r_error;
  assign pause        = (r_state == ST_HOLD);
  assign dbg_state    = r_state;

  always_comb begin
    w_next_count = r_count;
    if (w_wr_ok && !w_rd_ok) begin
      w_next_count = r_count + CNTW'(1);
    end else if (w_rd_ok && !w_wr_ok) begin
      w_next_count = r_count - CNTW'(1);
    end
  end

  // Storage is deliberately not reset; only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= Fifo_Data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_error        <= 1'b0;
      Fifo_Data_out  <= '0;
      Fifo_valid_out <= 1'b0;
    end else begin
      r_count        <= w_next_count;
      r_error        <= r_error || w_overflow || w_underflow;
      Fifo_valid_out <= w_rd_ok;
      if (w_wr_ok) begin
        r_wr_ptr <= (r_wr_ptr == PTRW'(LENGTH - 1)) ? '0 : r_wr_ptr + PTRW'(1);
      end
      if (w_rd_ok) begin
        Fifo_Data_out <= r_mem[r_rd_ptr];
        r_rd_ptr      <= (r_rd_ptr == PTRW'(LENGTH - 1)) ? '0 : r_rd_ptr + PTRW'(1);
      end
    end
  end

  // Pause decides on the post-edge count so it moves on the same edge as the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (w_next_count >= umbral_alto) w_state_nxt = ST_HOLD;
      ST_HOLD: if (w_next_count <= umbral_bajo) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Directed bench for fifo_flow_ctrl: an 8x8 instance for flow control and error
// cases, and a 6x16 instance for non-power-of-two pointer wrap.
module tb_fifo_flow_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // 8-deep, 8-bit instance
  logic       wr8 = 0, rd8 = 0;
  logic [7:0] din8 = '0, dout8;
  logic [3:0] alto8 = 4'd6, bajo8 = 4'd2, cnt8;
  logic       vld8, full8, empty8, af8, ae8, pause8, err8, dbg8;

  // 6-deep, 16-bit instance
  logic        wr6 = 0, rd6 = 0;
  logic [15:0] din6 = '0, dout6;
  logic [2:0]  alto6 = 3'd5, bajo6 = 3'd1, cnt6;
  logic        vld6, full6, empty6, af6, ae6, pause6, err6, dbg6;

  fifo_flow_ctrl #(.BITNUMBER(8), .LENGTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .Fifo_wr(wr8), .Fifo_Data_in(din8), .Fifo_rd(rd8),
    .umbral_alto(alto8), .umbral_bajo(bajo8), .Fifo_Data_out(dout8),
    .Fifo_valid_out(vld8), .full(full8), .empty(empty8), .almost_full(af8),
    .almost_empty(ae8), .fifo_count(cnt8), .pause(pause8), .error(err8),
    .dbg_state(dbg8)
  );

  fifo_flow_ctrl #(.BITNUMBER(16), .LENGTH(6)) u_dut6 (
    .clk(clk), .reset(reset), .Fifo_wr(wr6), .Fifo_Data_in(din6), .Fifo_rd(rd6),
    .umbral_alto(alto6), .umbral_bajo(bajo6), .Fifo_Data_out(dout6),
    .Fifo_valid_out(vld6), .full(full6), .empty(empty6), .almost_full(af6),
    .almost_empty(ae6), .fifo_count(cnt6), .pause(pause6), .error(err6),
    .dbg_state(dbg6)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    wr8 = 0; rd8 = 0; wr6 = 0; rd6 = 0;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic cyc8(input logic wr, input logic rd, input logic [7:0] d);
    @(negedge clk);
    wr8 = wr; rd8 = rd; din8 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc6(input logic wr, input logic rd, input logic [15:0] d);
    @(negedge clk);
    wr6 = wr; rd6 = rd; din6 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check8(input string tag);
    logic [15:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
    check({tag, "_valid"}, vld8, 1);
    check({tag, "_data"}, dout8, e);
  endtask

  task automatic pop_check6(input string tag);
    logic [15:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
    check({tag, "_valid"}, vld6, 1);
    check({tag, "_data"}, dout6, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rw_vals [3];
    rw_vals[0] = 8'hAA; rw_vals[1] = 8'hBB; rw_vals[2] = 8'hCC;

    // Reset state while reset is held low
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", cnt8, 0);
    check("rst_empty", empty8, 1);
    check("rst_aempty", ae8, 1);
    check("rst_full", full8, 0);
    check("rst_afull", af8, 0);
    check("rst_pause", pause8, 0);
    check("rst_error", err8, 0);
    check("rst_valid", vld8, 0);
    check("rst_dout", dout8, 0);
    check("rst_count6", cnt6, 0);

    // Basic write four, read four
    do_reset();
    cyc8(1, 0, 8'h0A); exp_q.push_back(16'h0A);
    check("t1_empty_after_first_wr", empty8, 0);
    cyc8(1, 0, 8'h0B); exp_q.push_back(16'h0B);
    cyc8(1, 0, 8'h0C); exp_q.push_back(16'h0C);
    cyc8(1, 0, 8'h0D); exp_q.push_back(16'h0D);
    check("t1_count4", cnt8, 4);
    check("t1_empty", empty8, 0);
    check("t1_pause", pause8, 0);
    for (int i = 0; i < 4; i++) begin
      cyc8(0, 1, 8'h00);
      pop_check8("t1_rd");
    end
    cyc8(0, 0, 8'h00);
    check("t1_valid_pulse_end", vld8, 0);
    check("t1_dout_hold", dout8, 8'h0D);
    check("t1_empty_end", empty8, 1);
    check("t1_error", err8, 0);

    // Fill to full with alto=6/bajo=2, overflow, then drain
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      cyc8(1, 0, 8'(i)); exp_q.push_back(16'(i));
      if (i == 5) check("t2_pause_at5", pause8, 0);
      if (i == 6) check("t2_pause_at6", pause8, 1);
      if (i == 7) begin
        check("t2_afull_at7", af8, 1);
        check("t2_full_at7", full8, 0);
      end
    end
    check("t2_full", full8, 1);
    cyc8(1, 0, 8'h09);
    check("t2_ovf_error", err8, 1);
    check("t2_ovf_count", cnt8, 8);
    for (int i = 1; i <= 8; i++) begin
      cyc8(0, 1, 8'h00);
      pop_check8("t2_rd");
      if (i == 5) check("t2_pause_cnt3", pause8, 1);
      if (i == 6) check("t2_pause_cnt2", pause8, 0);
      if (i == 7) check("t2_aempty_cnt1", ae8, 1);
    end
    check("t2_empty_end", empty8, 1);

    // Simultaneous read/write while full, then drain across the wrap
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      cyc8(1, 0, 8'(i)); exp_q.push_back(16'(i));
    end
    for (int k = 0; k < 3; k++) begin
      cyc8(1, 1, rw_vals[k]);
      pop_check8("t3_rw");
      exp_q.push_back({8'h00, rw_vals[k]});
      check("t3_rw_count", cnt8, 8);
      check("t3_rw_error", err8, 0);
    end
    check("t3_pause_full", pause8, 1);
    for (int i = 0; i < 8; i++) begin
      cyc8(0, 1, 8'h00);
      pop_check8("t3_drain");
    end
    check("t3_empty", empty8, 1);
    check("t3_error_end", err8, 0);

    // Simultaneous read/write while empty
    do_reset();
    cyc8(1, 1, 8'h55);
    check("t4_error", err8, 1);
    check("t4_count", cnt8, 1);
    check("t4_no_valid", vld8, 0);
    exp_q.push_back(16'h55);
    cyc8(0, 1, 8'h00);
    pop_check8("t4_rd");

    // 6-deep, 16-bit: interleaved traffic wraps the non-power-of-two pointers
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc6(1, 0, 16'h0100 + 16'(i)); exp_q.push_back(16'h0100 + 16'(i));
    end
    check("t5_count4", cnt6, 4);
    for (int i = 4; i < 10; i++) begin
      cyc6(1, 1, 16'h0100 + 16'(i));
      pop_check6("t5_rw");
      exp_q.push_back(16'h0100 + 16'(i));
      check("t5_rw_count", cnt6, 4);
    end
    for (int i = 0; i < 4; i++) begin
      cyc6(0, 1, 16'h0000);
      pop_check6("t5_drain");
    end
    check("t5_empty", empty6, 1);
    check("t5_error", err6, 0);
    check("t5_pause", pause6, 0);

    // Asynchronous reset mid-burst with pause asserted
    do_reset();
    alto8 = 4'd4; bajo8 = 4'd1;
    for (int i = 0; i < 5; i++) cyc8(1, 0, 8'h30 + 8'(i));
    check("t6_count5", cnt8, 5);
    check("t6_pause_pre", pause8, 1);
    @(negedge clk);
    wr8 = 0;
    #2 reset = 1'b0;
    #1;
    check("t6_async_count", cnt8, 0);
    check("t6_async_empty", empty8, 1);
    check("t6_async_pause", pause8, 0);
    check("t6_async_error", err8, 0);
    @(negedge clk);
    reset = 1'b1;
    alto8 = 4'd6; bajo8 = 4'd2;
    cyc8(0, 0, 8'h00);
    check("t6_post_empty", empty8, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
